// File: rtl/ps2_key_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_scheduler
//  Purpose  : Turns a PS/2 set-2 scan-code byte stream into Bomberman
//             per-player action events. Handles the break (F0) and
//             extended (E0) prefixes and tracks which mapped keys are held.
//             Each player has its own event FIFO. The two FIFOs are
//             arbitrated round-robin onto one valid/ready event port.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             code_byte[7:0]    - completed scan-code byte from the receiver
//             code_valid        - one-cycle strobe qualifying code_byte
//             evt_valid/ready   - event handshake (transfer on both high)
//             evt_player        - 0 = player 0, 1 = player 1
//             evt_action[2:0]   - 0 up, 1 down, 2 left, 3 right, 4 bomb
//             evt_press         - 1 = make, 0 = break
//             keys_held[9:0]    - P1 {bomb,right,left,down,up}, then P0
//             overflow[1:0]     - per-player pulse when an event is dropped
//  Options  : KEY_SCHED_TYPEMATIC_FILTER_EN - when defined, typematic
//             repeats and breaks of keys that are not held make no event.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_key_scheduler #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code_byte,
    input  logic       code_valid,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic       evt_player,
    output logic [2:0] evt_action,
    output logic       evt_press,
    output logic [9:0] keys_held,
    output logic [1:0] overflow
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam logic [c_aw:0] c_ptr_one = 1;

    // Parser states
    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_brk     = 2'd1;
    localparam logic [1:0] c_st_ext     = 2'd2;
    localparam logic [1:0] c_st_ext_brk = 2'd3;

    localparam logic [7:0] c_code_brk = 8'hF0;
    localparam logic [7:0] c_code_ext = 8'hE0;

    // ------------------------------------------------------------------
    // Prefix parser: state register / next-state / lookup outputs
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       w_lookup_en;
    logic       w_lookup_brk;
    logic       w_lookup_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (code_valid) begin
            case (r_state)
                c_st_idle: begin
                    if (code_byte == c_code_brk)      w_state_next = c_st_brk;
                    else if (code_byte == c_code_ext) w_state_next = c_st_ext;
                    else                              w_state_next = c_st_idle;
                end
                c_st_ext: begin
                    if (code_byte == c_code_brk)      w_state_next = c_st_ext_brk;
                    else if (code_byte == c_code_ext) w_state_next = c_st_ext;
                    else                              w_state_next = c_st_idle;
                end
                default: w_state_next = c_st_idle;
            endcase
        end
    end

    // Which byte is a key lookup, and with which prefix flags.
    always_comb begin
        w_lookup_en  = 1'b0;
        w_lookup_brk = 1'b0;
        w_lookup_ext = 1'b0;
        if (code_valid) begin
            case (r_state)
                c_st_idle: begin
                    w_lookup_en = (code_byte != c_code_brk) && (code_byte != c_code_ext);
                end
                c_st_ext: begin
                    w_lookup_en  = (code_byte != c_code_brk) && (code_byte != c_code_ext);
                    w_lookup_ext = 1'b1;
                end
                c_st_brk: begin
                    w_lookup_en  = 1'b1;
                    w_lookup_brk = 1'b1;
                end
                default: begin
                    w_lookup_en  = 1'b1;
                    w_lookup_brk = 1'b1;
                    w_lookup_ext = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Key map
    // ------------------------------------------------------------------
    logic       w_map_hit;
    logic       w_map_player;
    logic [2:0] w_map_action;

    always_comb begin
        w_map_hit    = 1'b0;
        w_map_player = 1'b0;
        w_map_action = 3'd0;
        if (w_lookup_en) begin
            case ({w_lookup_ext, code_byte})
                9'h01D: begin w_map_hit = 1'b1; w_map_player = 1'b0; w_map_action = 3'd0; end
                9'h01B: begin w_map_hit = 1'b1; w_map_player = 1'b0; w_map_action = 3'd1; end
                9'h01C: begin w_map_hit = 1'b1; w_map_player = 1'b0; w_map_action = 3'd2; end
                9'h023: begin w_map_hit = 1'b1; w_map_player = 1'b0; w_map_action = 3'd3; end
                9'h029: begin w_map_hit = 1'b1; w_map_player = 1'b0; w_map_action = 3'd4; end
                9'h175: begin w_map_hit = 1'b1; w_map_player = 1'b1; w_map_action = 3'd0; end
                9'h172: begin w_map_hit = 1'b1; w_map_player = 1'b1; w_map_action = 3'd1; end
                9'h16B: begin w_map_hit = 1'b1; w_map_player = 1'b1; w_map_action = 3'd2; end
                9'h174: begin w_map_hit = 1'b1; w_map_player = 1'b1; w_map_action = 3'd3; end
                9'h05A: begin w_map_hit = 1'b1; w_map_player = 1'b1; w_map_action = 3'd4; end
                default: begin
                    w_map_hit    = 1'b0;
                    w_map_player = 1'b0;
                    w_map_action = 3'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Held-key bitmap and event generation
    // ------------------------------------------------------------------
    logic [9:0] r_keys_held;
    logic [3:0] w_key_idx;
    logic [9:0] w_key_mask;
    logic       w_key_was_held;
    logic       w_evt_gen;
    logic [1:0] w_push_req;

    assign w_key_idx      = w_map_player ? (4'd5 + {1'b0, w_map_action}) : {1'b0, w_map_action};
    assign w_key_mask     = 10'b1 << w_key_idx;
    assign w_key_was_held = |(r_keys_held & w_key_mask);

`ifdef KEY_SCHED_TYPEMATIC_FILTER_EN
    // Only edges of the held state become events.
    assign w_evt_gen = w_map_hit && (w_lookup_brk ? w_key_was_held : !w_key_was_held);
`else
    assign w_evt_gen = w_map_hit;
`endif

    assign w_push_req[0] = w_evt_gen && !w_map_player;
    assign w_push_req[1] = w_evt_gen &&  w_map_player;

    // The bitmap follows the key regardless of FIFO space.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_keys_held <= 10'd0;
        end else if (w_map_hit) begin
            if (w_lookup_brk) r_keys_held <= r_keys_held & ~w_key_mask;
            else              r_keys_held <= r_keys_held |  w_key_mask;
        end
    end

    // ------------------------------------------------------------------
    // Per-player event FIFOs; entry = {action, press}
    // ------------------------------------------------------------------
    logic [1:0] w_empty;
    logic [1:0] w_full;
    logic [1:0] w_pop;
    logic [1:0] w_push_ok;
    logic [1:0] w_drop;
    logic [3:0] w_head [2];
    logic [3:0] w_entry;

    assign w_entry = {w_map_action, !w_lookup_brk};

    for (genvar p = 0; p < 2; p++) begin : g_fifo
        logic [3:0]    r_mem [FIFO_DEPTH];
        logic [c_aw:0] r_wr_ptr;
        logic [c_aw:0] r_rd_ptr;

        assign w_empty[p] = (r_wr_ptr == r_rd_ptr);
        // Extra pointer MSB distinguishes full from empty.
        assign w_full[p]  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                            (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
        // A full FIFO being popped this cycle still has room for the push.
        assign w_push_ok[p] = w_push_req[p] && (!w_full[p] || w_pop[p]);
        assign w_drop[p]    = w_push_req[p] && w_full[p] && !w_pop[p];
        assign w_head[p]    = r_mem[r_rd_ptr[c_aw-1:0]];

        always_ff @(posedge clk) begin
            if (w_push_ok[p]) begin
                r_mem[r_wr_ptr[c_aw-1:0]] <= w_entry;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push_ok[p]) r_wr_ptr <= r_wr_ptr + c_ptr_one;
                if (w_pop[p])     r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    logic r_hold;        // an event was presented and not yet taken
    logic r_hold_grant;  // player that event belongs to
    logic r_last;        // player served by the most recent transfer
    logic w_grant;
    logic w_valid;
    logic w_xfer;
    logic [1:0] r_overflow;

    // While an event is stalled the grant is frozen so a push into the
    // other FIFO cannot swap the presented event.
    always_comb begin
        w_grant = 1'b0;
        if (r_hold)                    w_grant = r_hold_grant;
        else if (w_empty == 2'b00)     w_grant = ~r_last;
        else if (!w_empty[1])          w_grant = 1'b1;
        else                           w_grant = 1'b0;
    end

    assign w_valid  = r_hold || (w_empty != 2'b11);
    assign w_xfer   = w_valid && evt_ready;
    assign w_pop[0] = w_xfer && !w_grant;
    assign w_pop[1] = w_xfer &&  w_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold       <= 1'b0;
            r_hold_grant <= 1'b0;
            r_last       <= 1'b1;   // player 0 wins the first tie
            r_overflow   <= 2'b00;
        end else begin
            r_hold       <= w_valid && !evt_ready;
            r_hold_grant <= w_grant;
            if (w_xfer) r_last <= w_grant;
            r_overflow   <= w_drop;
        end
    end

    assign evt_valid  = w_valid;
    assign evt_player = w_valid && w_grant;
    assign evt_action = w_valid ? w_head[w_grant][3:1] : 3'd0;
    assign evt_press  = w_valid && w_head[w_grant][0];
    assign keys_held  = r_keys_held;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_key_scheduler
//  Purpose  : Directed self-checking bench for ps2_key_scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_scheduler;

    logic       clk;
    logic       rst;
    logic [7:0] code_byte;
    logic       code_valid;
    logic       evt_valid;
    logic       evt_ready;
    logic       evt_player;
    logic [2:0] evt_action;
    logic       evt_press;
    logic [9:0] keys_held;
    logic [1:0] overflow;

    int errors = 0;
    int checks = 0;

    // Accepted events as {player, action, press}; overflow pulse counts.
    logic [4:0] cap_q[$];
    int ovf0_cnt = 0;
    int ovf1_cnt = 0;

    ps2_key_scheduler #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .code_byte  (code_byte),
        .code_valid (code_valid),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_player (evt_player),
        .evt_action (evt_action),
        .evt_press  (evt_press),
        .keys_held  (keys_held),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after posedge, so negedge sees the values the
    // next posedge will act on.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) cap_q.push_back({evt_player, evt_action, evt_press});
        if (!rst && overflow[0]) ovf0_cnt++;
        if (!rst && overflow[1]) ovf1_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        code_byte  = b;
        code_valid = 1'b1;
        tick(1);
        code_valid = 1'b0;
        code_byte  = 8'h00;
    endtask

    task automatic test_reset;
        rst = 1'b1; code_valid = 1'b0; code_byte = 8'h00; evt_ready = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        checks++;
        if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
        checks++;
        if (keys_held !== 10'd0) begin errors++; $display("FAIL reset_keys: got %h want 000", keys_held); end
        checks++;
        if ({overflow, evt_player, evt_action, evt_press} !== 7'd0) begin
            errors++;
            $display("FAIL reset_fields: got %b want 0000000", {overflow, evt_player, evt_action, evt_press});
        end
    endtask

    task automatic test_p0_make_break;
        int base;
        base = cap_q.size();
        evt_ready = 1'b1;
        send(8'h1D);
        checks++;
        if (keys_held !== 10'h001) begin errors++; $display("FAIL p0_make_keys: got %h want 001", keys_held); end
        checks++;
        if ({evt_valid, evt_player, evt_action, evt_press} !== 6'b1_0_000_1) begin
            errors++;
            $display("FAIL p0_make_latency: got %b want 100001", {evt_valid, evt_player, evt_action, evt_press});
        end
        send(8'hF0);
        send(8'h1D);
        tick(2);
        checks++;
        if (keys_held !== 10'h000) begin errors++; $display("FAIL p0_break_keys: got %h want 000", keys_held); end
        checks++;
        if (cap_q.size() - base !== 2) begin
            errors++; $display("FAIL p0_evt_count: got %0d want 2", cap_q.size() - base);
        end else begin
            checks++;
            if (cap_q[base] !== 5'h01) begin errors++; $display("FAIL p0_evt0: got %h want 01", cap_q[base]); end
            checks++;
            if (cap_q[base+1] !== 5'h00) begin errors++; $display("FAIL p0_evt1: got %h want 00", cap_q[base+1]); end
        end
    endtask

    task automatic test_p1_extended;
        int base;
        base = cap_q.size();
        evt_ready = 1'b1;
        send(8'hE0); send(8'h74);
        checks++;
        if (keys_held !== 10'h100) begin errors++; $display("FAIL p1_make_keys: got %h want 100", keys_held); end
        tick(2);
        send(8'hE0); send(8'hF0); send(8'h74);
        tick(2);
        checks++;
        if (keys_held !== 10'h000) begin errors++; $display("FAIL p1_break_keys: got %h want 000", keys_held); end
        checks++;
        if (cap_q.size() - base !== 2) begin
            errors++; $display("FAIL p1_evt_count: got %0d want 2", cap_q.size() - base);
        end else begin
            checks++;
            if (cap_q[base] !== 5'h17) begin errors++; $display("FAIL p1_evt0: got %h want 17", cap_q[base]); end
            checks++;
            if (cap_q[base+1] !== 5'h16) begin errors++; $display("FAIL p1_evt1: got %h want 16", cap_q[base+1]); end
        end
        // Non-extended 74 is unmapped.
        base = cap_q.size();
        send(8'h74);
        tick(3);
        checks++;
        if (cap_q.size() - base !== 0) begin errors++; $display("FAIL p1_nonext_evt: got %0d want 0", cap_q.size() - base); end
        checks++;
        if (keys_held !== 10'h000) begin errors++; $display("FAIL p1_nonext_keys: got %h want 000", keys_held); end
    endtask

    task automatic test_arbiter_hold;
        int base;
        base = cap_q.size();
        evt_ready = 1'b0;
        send(8'h29);
        send(8'h5A);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({evt_valid, evt_player, evt_action, evt_press} !== 6'b1_0_100_1) begin
                errors++;
                $display("FAIL hold_stable[%0d]: got %b want 101001", i, {evt_valid, evt_player, evt_action, evt_press});
            end
            tick(1);
        end
        checks++;
        if (keys_held !== 10'h210) begin errors++; $display("FAIL hold_keys: got %h want 210", keys_held); end
        evt_ready = 1'b1;
        tick(1);
        checks++;
        if ({evt_valid, evt_player, evt_action, evt_press} !== 6'b1_1_100_1) begin
            errors++;
            $display("FAIL hold_second: got %b want 111001", {evt_valid, evt_player, evt_action, evt_press});
        end
        tick(1);
        checks++;
        if (evt_valid !== 1'b0) begin errors++; $display("FAIL hold_drained: got %b want 0", evt_valid); end
        checks++;
        if (cap_q.size() - base !== 2) begin
            errors++; $display("FAIL hold_evt_count: got %0d want 2", cap_q.size() - base);
        end else begin
            checks++;
            if (cap_q[base] !== 5'h09) begin errors++; $display("FAIL hold_evt0: got %h want 09", cap_q[base]); end
            checks++;
            if (cap_q[base+1] !== 5'h19) begin errors++; $display("FAIL hold_evt1: got %h want 19", cap_q[base+1]); end
        end
        send(8'hF0); send(8'h29); send(8'hF0); send(8'h5A);
        tick(3);
    endtask

    task automatic test_overflow;
        int base;
        int ob0;
        int ob1;
        base = cap_q.size();
        ob0 = ovf0_cnt;
        ob1 = ovf1_cnt;
        evt_ready = 1'b0;
        send(8'h1D); send(8'h1B); send(8'h1C); send(8'h23);
        checks++;
        if (overflow !== 2'b00) begin errors++; $display("FAIL ovf_none_yet: got %b want 00", overflow); end
        send(8'h29);
        checks++;
        if (overflow !== 2'b01) begin errors++; $display("FAIL ovf_pulse: got %b want 01", overflow); end
        tick(1);
        checks++;
        if (overflow !== 2'b00) begin errors++; $display("FAIL ovf_one_cycle: got %b want 00", overflow); end
        checks++;
        if (keys_held !== 10'h01F) begin errors++; $display("FAIL ovf_keys: got %h want 01f", keys_held); end
        evt_ready = 1'b1;
        tick(6);
        checks++;
        if (ovf0_cnt - ob0 !== 1 || ovf1_cnt - ob1 !== 0) begin
            errors++; $display("FAIL ovf_counts: got %0d/%0d want 1/0", ovf0_cnt - ob0, ovf1_cnt - ob1);
        end
        checks++;
        if (cap_q.size() - base !== 4) begin
            errors++; $display("FAIL ovf_evt_count: got %0d want 4", cap_q.size() - base);
        end else begin
            checks++;
            if ({cap_q[base], cap_q[base+1], cap_q[base+2], cap_q[base+3]} !== {5'h01, 5'h03, 5'h05, 5'h07}) begin
                errors++;
                $display("FAIL ovf_order: got %h %h %h %h want 01 03 05 07",
                         cap_q[base], cap_q[base+1], cap_q[base+2], cap_q[base+3]);
            end
        end
        send(8'hF0); send(8'h1D); send(8'hF0); send(8'h1B); send(8'hF0); send(8'h1C);
        send(8'hF0); send(8'h23); send(8'hF0); send(8'h29);
        tick(4);
        checks++;
        if (keys_held !== 10'h000) begin errors++; $display("FAIL ovf_release_keys: got %h want 000", keys_held); end
    endtask

    task automatic test_typematic;
        int base;
        int want;
`ifdef KEY_SCHED_TYPEMATIC_FILTER_EN
        want = 2;
`else
        want = 4;
`endif
        base = cap_q.size();
        evt_ready = 1'b1;
        send(8'h1D); send(8'h1D); send(8'h1D); send(8'hF0); send(8'h1D);
        tick(3);
        checks++;
        if (cap_q.size() - base !== want) begin
            errors++; $display("FAIL typematic_count: got %0d want %0d", cap_q.size() - base, want);
        end else begin
            checks++;
            if (cap_q[base] !== 5'h01 || cap_q[base+want-1] !== 5'h00) begin
                errors++;
                $display("FAIL typematic_ends: got %h..%h want 01..00", cap_q[base], cap_q[base+want-1]);
            end
        end
        checks++;
        if (keys_held !== 10'h000) begin errors++; $display("FAIL typematic_keys: got %h want 000", keys_held); end
    endtask

    task automatic test_reset_prefix;
        int base;
        evt_ready = 1'b1;
        send(8'hF0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        base = cap_q.size();
        send(8'h1D);
        tick(2);
        checks++;
        if (keys_held !== 10'h001) begin errors++; $display("FAIL rstpfx_keys: got %h want 001", keys_held); end
        checks++;
        if (cap_q.size() - base !== 1) begin
            errors++; $display("FAIL rstpfx_count: got %0d want 1", cap_q.size() - base);
        end else begin
            checks++;
            if (cap_q[base] !== 5'h01) begin errors++; $display("FAIL rstpfx_evt: got %h want 01", cap_q[base]); end
        end
    endtask

    initial begin
        rst = 1'b1; code_valid = 1'b0; code_byte = 8'h00; evt_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_p0_make_break();
        test_p1_extended();
        test_arbiter_hold();
        test_overflow();
        test_typematic();
        test_reset_prefix();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
